// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32I fetch stage.
package fetch_pkg;

   localparam int unsigned DataW = 32;
   localparam logic [DataW-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [DataW-1:0] addr;
      logic [DataW-1:0] instr;
      logic             fault;
   } fetch_entry_t;

   // Counters must hold the value depth itself, hence one extra bit.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_r32i.sv
// Synchronous FIFO with clear; Depth must be a power of two so the pointers wrap naturally.
module fifo_r32i #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_clear,
   output logic             o_full,
   output logic             o_empty,
   output logic [Width-1:0] o_head
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] r_mem [Depth];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == (AW+1)'(Depth));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   // Storage needs no reset; occupancy gates every read.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/fetch_r32i.sv
// RV32I instruction fetch stage: credit-limited memory reads, flush-safe response tracking.
// Optional build macro FETCH_MISALIGN_CHECK_EN turns misaligned addresses into fault entries.
module fetch_r32i
   import fetch_pkg::*;
#(
   parameter int unsigned dataW = DataW,
   parameter int unsigned depth = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [dataW-1:0] i_fetch_addr,
   input  logic             i_fetch_valid,
   output logic             o_fetch_ready,
   input  logic             i_flush,
   output logic             o_mem_req,
   output logic [dataW-1:0] o_mem_addr,
   input  logic             i_mem_gnt,
   input  logic             i_mem_rvalid,
   input  logic [dataW-1:0] i_mem_rdata,
   output logic             o_instr_valid,
   output logic [dataW-1:0] o_instr,
   output logic [dataW-1:0] o_instr_addr,
   output logic             o_instr_fault,
   input  logic             i_instr_ready
);

   localparam int unsigned CW = cnt_width(depth);
   localparam int unsigned SW = CW + 2;

   logic [CW-1:0]    r_out;
   logic [CW-1:0]    r_drop;
   logic [CW-1:0]    r_occ;
   logic [SW-1:0]    w_used;
   logic             w_credit;
   logic             w_aligned;
   logic             w_fault_acc;
   logic             w_issue;
   logic             w_pop;
   logic             w_resp_drop;
   logic             w_resp_live;
   logic             w_push_out;
   logic             w_pend_full;
   logic             w_pend_empty;
   logic [dataW-1:0] w_pend_head;
   logic             w_out_full;
   logic             w_out_empty;
   fetch_entry_t     w_new_entry;
   fetch_entry_t     w_head;

   assign o_instr_valid = !w_out_empty;
   assign w_pop         = o_instr_valid && i_instr_ready;
   assign w_used        = SW'(r_out) + SW'(r_drop) + SW'(r_occ) - SW'(w_pop);
   assign w_credit      = (w_used < SW'(depth));

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_aligned   = (i_fetch_addr[1:0] == 2'b00);
   // Faults wait for an idle memory path so they stay in order with real responses.
   assign w_fault_acc = !reset && i_fetch_valid && !w_aligned && w_credit &&
                        (r_out == '0) && (r_drop == '0) && !i_flush;
   assign o_instr_fault = o_instr_valid ? w_head.fault : 1'b0;
`else
   assign w_aligned     = 1'b1;
   assign w_fault_acc   = 1'b0;
   assign o_instr_fault = 1'b0;
`endif

   assign o_mem_req     = !reset && i_fetch_valid && w_credit && !i_flush && w_aligned;
   assign o_mem_addr    = reset ? '0 : {i_fetch_addr[dataW-1:2], 2'b00};
   assign w_issue       = o_mem_req && i_mem_gnt;
   assign o_fetch_ready = w_issue || w_fault_acc;

   assign w_resp_drop = i_mem_rvalid && (r_drop != '0);
   assign w_resp_live = i_mem_rvalid && (r_drop == '0) && (r_out != '0);
   assign w_push_out  = (w_resp_live || w_fault_acc) && !i_flush;

   always_comb begin
      w_new_entry       = '0;
      w_new_entry.addr  = w_fault_acc ? i_fetch_addr : w_pend_head;
      w_new_entry.instr = w_fault_acc ? NOP_INSTR : i_mem_rdata;
      w_new_entry.fault = w_fault_acc;
   end

   fifo_r32i #(
      .Width(dataW),
      .Depth(depth)
   ) u_pend_fifo (
      .clock  (clock),
      .reset  (reset),
      .i_push (w_issue),
      .i_data (i_fetch_addr),
      .i_pop  (w_resp_live),
      .i_clear(i_flush),
      .o_full (w_pend_full),
      .o_empty(w_pend_empty),
      .o_head (w_pend_head)
   );

   fifo_r32i #(
      .Width($bits(fetch_entry_t)),
      .Depth(depth)
   ) u_out_fifo (
      .clock  (clock),
      .reset  (reset),
      .i_push (w_push_out),
      .i_data (w_new_entry),
      .i_pop  (w_pop),
      .i_clear(i_flush),
      .o_full (w_out_full),
      .o_empty(w_out_empty),
      .o_head (w_head)
   );

   assign o_instr      = o_instr_valid ? w_head.instr : '0;
   assign o_instr_addr = o_instr_valid ? w_head.addr : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out  <= '0;
         r_drop <= '0;
         r_occ  <= '0;
      end else if (i_flush) begin
         // Everything live becomes a drop; a response this cycle retires one of them.
         r_out  <= '0;
         r_drop <= r_drop + r_out - CW'(w_resp_drop || w_resp_live);
         r_occ  <= '0;
      end else begin
         r_out  <= r_out + CW'(w_issue) - CW'(w_resp_live);
         r_drop <= r_drop - CW'(w_resp_drop);
         r_occ  <= r_occ + CW'(w_push_out) - CW'(w_pop);
      end
   end

   a_no_orphan_resp: assert property (@(posedge clock) disable iff (reset)
      !(i_mem_rvalid && (r_out == '0) && (r_drop == '0)));
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(w_issue && w_pend_full) && !(w_push_out && w_out_full));
   a_pend_tracks: assert property (@(posedge clock) disable iff (reset)
      !(w_resp_live && w_pend_empty));
`ifndef FETCH_MISALIGN_CHECK_EN
   a_no_fault: assert property (@(posedge clock) disable iff (reset)
      !(o_instr_valid && w_head.fault));
`endif

endmodule

// File: tb/tb_fetch_r32i.sv
// Directed self-checking bench for fetch_r32i with an in-order, fixed-latency memory model.
module tb_fetch_r32i;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] fetch_addr = '0;
   logic        fetch_valid = 1'b0;
   logic        fetch_ready;
   logic        flush = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b1;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_addr;
   logic        instr_fault;
   logic        instr_ready = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lat = 1;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;
   rsp_t q[$];

   fetch_r32i u_dut (
      .clock        (clock),
      .reset        (reset),
      .i_fetch_addr (fetch_addr),
      .i_fetch_valid(fetch_valid),
      .o_fetch_ready(fetch_ready),
      .i_flush      (flush),
      .o_mem_req    (mem_req),
      .o_mem_addr   (mem_addr),
      .i_mem_gnt    (mem_gnt),
      .i_mem_rvalid (mem_rvalid),
      .i_mem_rdata  (mem_rdata),
      .o_instr_valid(instr_valid),
      .o_instr      (instr),
      .o_instr_addr (instr_addr),
      .o_instr_fault(instr_fault),
      .i_instr_ready(instr_ready)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return 32'hC0DE_0000 | a;
   endfunction

   // Memory: responds in order, lat cycles after the grant edge; shares the DUT reset.
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (reset) begin
            q.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
         end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
               mem_rvalid = 1'b1;
               mem_rdata  = q[0].data;
               void'(q.pop_front());
            end else begin
               mem_rvalid = 1'b0;
               mem_rdata  = '0;
            end
            if (mem_req && mem_gnt) q.push_back('{due: cyc + lat, data: mdata(mem_addr)});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'h8; instr_ready = 1'b1;
      tick(); #3;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
      total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL rst_fetch_ready got=%b want=0", fetch_ready); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b want=0", instr_valid); end
      total++; if ({instr, instr_addr, instr_fault} !== 65'h0) begin bad++; $display("FAIL rst_instr got=%h/%h/%b want=0", instr, instr_addr, instr_fault); end
      fetch_valid = 1'b0; fetch_addr = '0;
      tick(); reset = 1'b0; #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", instr_valid); end
   endtask

   task automatic test_streaming();
      logic        ev;
      logic [31:0] ea;
      lat = 1; instr_ready = 1'b1;
      for (int t = 0; t < 7; t++) begin
         tick();
         fetch_valid = (t < 4);
         fetch_addr  = (t < 4) ? 32'(4 * t) : 32'h0;
         #3;
         if (t < 4) begin
            total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL stream_ready t=%0d got=%b want=1", t, fetch_ready); end
            total++; if (mem_addr !== 32'(4 * t)) begin bad++; $display("FAIL stream_mem_addr t=%0d got=%h want=%h", t, mem_addr, 32'(4 * t)); end
         end
         ev = (t >= 2 && t < 6);
         ea = ev ? 32'(4 * (t - 2)) : 32'h0;
         total++; if (instr_valid !== ev) begin bad++; $display("FAIL stream_valid t=%0d got=%b want=%b", t, instr_valid, ev); end
         total++; if (instr_addr !== ea) begin bad++; $display("FAIL stream_addr t=%0d got=%h want=%h", t, instr_addr, ea); end
         total++; if (instr !== (ev ? mdata(ea) : 32'h0)) begin bad++; $display("FAIL stream_instr t=%0d got=%h want=%h", t, instr, ev ? mdata(ea) : 32'h0); end
      end
      fetch_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int issued = 0;
      lat = 1; instr_ready = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         fetch_valid = 1'b1;
         fetch_addr  = 32'h40 + 32'(4 * issued);
         #3;
         if (fetch_ready) issued++;
      end
      total++; if (issued !== 4) begin bad++; $display("FAIL bp_issue_count got=%0d want=4", issued); end
      total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", fetch_ready); end
      tick();
      instr_ready = 1'b1; fetch_addr = 32'h50; fetch_valid = 1'b1;
      #3;
      total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b want=1", fetch_ready); end
      total++; if (instr_addr !== 32'h40) begin bad++; $display("FAIL bp_head got=%h want=00000040", instr_addr); end
      for (int k = 1; k <= 5; k++) begin
         tick(); fetch_valid = 1'b0; #3;
         total++; if (instr_valid !== (k <= 4)) begin bad++; $display("FAIL bp_drain_valid k=%0d got=%b want=%b", k, instr_valid, k <= 4); end
         if (k <= 4) begin
            total++; if (instr_addr !== 32'h40 + 32'(4 * k)) begin bad++; $display("FAIL bp_drain_addr k=%0d got=%h want=%h", k, instr_addr, 32'h40 + 32'(4 * k)); end
         end
      end
   endtask

   task automatic test_flush_in_flight();
      lat = 3; instr_ready = 1'b1;
      tick(); fetch_valid = 1'b1; fetch_addr = 32'h10; #3;
      total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL fl_issue0 got=%b want=1", fetch_ready); end
      tick(); fetch_addr = 32'h14; #3;
      total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL fl_issue1 got=%b want=1", fetch_ready); end
      tick(); flush = 1'b1; fetch_addr = 32'h100; #3;
      total++; if ({fetch_ready, mem_req} !== 2'b00) begin bad++; $display("FAIL fl_no_issue got=%b%b want=00", fetch_ready, mem_req); end
      for (int c = 3; c <= 8; c++) begin
         tick(); flush = 1'b0; fetch_valid = (c == 3); #3;
         if (c == 3) begin
            total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL fl_redirect got=%b want=1", fetch_ready); end
         end
         total++; if (instr_valid !== (c == 7)) begin bad++; $display("FAIL fl_valid c=%0d got=%b want=%b", c, instr_valid, c == 7); end
         if (c == 7) begin
            total++; if (instr_addr !== 32'h100) begin bad++; $display("FAIL fl_addr got=%h want=00000100", instr_addr); end
            total++; if (instr !== mdata(32'h100)) begin bad++; $display("FAIL fl_instr got=%h want=%h", instr, mdata(32'h100)); end
         end
      end
      total++; if (u_dut.r_drop !== '0) begin bad++; $display("FAIL fl_drop_zero got=%0d want=0", u_dut.r_drop); end
   endtask

   task automatic test_flush_resp_pop();
      int acc = 0;
      lat = 1; instr_ready = 1'b1;
      tick(); fetch_valid = 1'b1; fetch_addr = 32'h200;
      tick(); fetch_addr = 32'h204;
      tick(); fetch_valid = 1'b0; flush = 1'b1; #3;
      total++; if (instr_addr !== 32'h200) begin bad++; $display("FAIL frp_pop_head got=%h want=00000200", instr_addr); end
      tick(); flush = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h300; #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL frp_no_phantom got=%b want=0", instr_valid); end
      total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL frp_ready got=%b want=1", fetch_ready); end
      tick(); fetch_valid = 1'b0; #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL frp_gap got=%b want=0", instr_valid); end
      tick(); #3;
      total++; if ({instr_valid, instr_addr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL frp_redirect got=%b/%h want=1/00000300", instr_valid, instr_addr); end
      tick(); instr_ready = 1'b0; #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL frp_empty got=%b want=0", instr_valid); end
      for (int t = 0; t < 6; t++) begin
         tick(); fetch_valid = 1'b1; fetch_addr = 32'h400 + 32'(4 * acc); #3;
         if (fetch_ready) acc++;
      end
      total++; if (acc !== 4) begin bad++; $display("FAIL frp_credit got=%0d want=4", acc); end
      tick(); fetch_valid = 1'b0; instr_ready = 1'b1; #3;
      total++; if (instr_addr !== 32'h400) begin bad++; $display("FAIL frp_drain_head got=%h want=00000400", instr_addr); end
      for (int t = 0; t < 5; t++) tick();
      #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL frp_drained got=%b want=0", instr_valid); end
   endtask

   task automatic test_reset_outstanding();
      lat = 3; instr_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick(); fetch_valid = 1'b1; fetch_addr = 32'h20 + 32'(4 * c); #3;
         total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL ro_issue c=%0d got=%b want=1", c, fetch_ready); end
      end
      tick(); fetch_addr = 32'h30; #3;
      total++; if ({instr_valid, instr_addr} !== {1'b1, 32'h20}) begin bad++; $display("FAIL ro_pre got=%b/%h want=1/00000020", instr_valid, instr_addr); end
      reset = 1'b1; #1;
      total++; if ({mem_req, fetch_ready, instr_valid, instr_fault} !== 4'b0000) begin bad++; $display("FAIL ro_async_ctl got=%b want=0000", {mem_req, fetch_ready, instr_valid, instr_fault}); end
      total++; if ({instr, instr_addr, mem_addr} !== 96'h0) begin bad++; $display("FAIL ro_async_data got=%h/%h/%h want=0", instr, instr_addr, mem_addr); end
      fetch_valid = 1'b0;
      tick(); tick(); reset = 1'b0; lat = 1; instr_ready = 1'b1;
      tick(); fetch_valid = 1'b1; fetch_addr = 32'h0; #3;
      total++; if ({fetch_ready, mem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL ro_refetch got=%b/%h want=1/0", fetch_ready, mem_addr); end
      tick(); fetch_valid = 1'b0; #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ro_stale got=%b want=0", instr_valid); end
      tick(); #3;
      total++; if ({instr_valid, instr_addr, instr} !== {1'b1, 32'h0, mdata(32'h0)}) begin bad++; $display("FAIL ro_first got=%b/%h/%h want=1/0/%h", instr_valid, instr_addr, instr, mdata(32'h0)); end
   endtask

   task automatic test_misalign();
      lat = 1; instr_ready = 1'b1;
      tick(); fetch_valid = 1'b1; fetch_addr = 32'h6; #3;
`ifdef FETCH_MISALIGN_CHECK_EN
      total++; if ({mem_req, fetch_ready} !== 2'b01) begin bad++; $display("FAIL mis_accept got=%b%b want=01", mem_req, fetch_ready); end
      tick(); fetch_valid = 1'b0; #3;
      total++; if ({instr_valid, instr_addr, instr, instr_fault} !== {1'b1, 32'h6, 32'h13, 1'b1}) begin bad++; $display("FAIL mis_entry got=%b/%h/%h/%b want=1/6/13/1", instr_valid, instr_addr, instr, instr_fault); end
      tick(); #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_after got=%b want=0", instr_valid); end
`else
      total++; if ({mem_req, fetch_ready, mem_addr} !== {2'b11, 32'h4}) begin bad++; $display("FAIL mis_issue got=%b%b/%h want=11/4", mem_req, fetch_ready, mem_addr); end
      tick(); fetch_valid = 1'b0; #3;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_wait got=%b want=0", instr_valid); end
      tick(); #3;
      total++; if ({instr_valid, instr_addr, instr, instr_fault} !== {1'b1, 32'h6, mdata(32'h4), 1'b0}) begin bad++; $display("FAIL mis_entry got=%b/%h/%h/%b want=1/6/%h/0", instr_valid, instr_addr, instr, instr_fault, mdata(32'h4)); end
`endif
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_in_flight();
      test_flush_resp_pop();
      test_reset_outstanding();
      test_misalign();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
